// File: rtl/vscale_xvec_lsu.sv
// Vector load/store sequencer: strided word accesses assembled into / sliced from one wide operand.
// Optional per-lane masking is enabled by defining XVEC_LSU_MASK_EN.
module vscale_xvec_lsu #(
    parameter int unsigned XPR_LEN = 32,
    parameter int unsigned LANES   = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     is_store_i,
    input  logic [31:0]              base_addr_i,
    input  logic [31:0]              stride_i,
    input  logic [4:0]               wa_i,
    input  logic [LANES*XPR_LEN-1:0] store_data_i,
`ifdef XVEC_LSU_MASK_EN
    input  logic [LANES-1:0]         lane_mask_i,
`endif
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     wb_en_o,
    output logic [4:0]               wb_addr_o,
    output logic [LANES*XPR_LEN-1:0] wb_data_o,
    output logic                     mem_req_o,
    output logic                     mem_wen_o,
    output logic [31:0]              mem_addr_o,
    output logic [XPR_LEN-1:0]       mem_wdata_o,
    input  logic [XPR_LEN-1:0]       mem_rdata_i,
    input  logic                     mem_wait_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StFin   = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [LANES-1:0]         rem_q, rem_d;
    logic                     dp_valid_q, dp_valid_d;
    logic [CNT_W-1:0]         dp_lane_q, dp_lane_d;
    logic                     is_store_q, is_store_d;
    logic                     err_q, err_d;
    logic [31:0]              base_q, base_d;
    logic [31:0]              stride_q, stride_d;
    logic [4:0]               wa_q, wa_d;
    logic [LANES*XPR_LEN-1:0] sdata_q, sdata_d;
    logic [LANES*XPR_LEN-1:0] wb_data_q, wb_data_d;

    logic [LANES-1:0]         start_mask;
    logic [CNT_W-1:0]         cur_lane;
    logic [XPR_LEN-1:0]       wdata_lane;
    logic                     misaligned;

`ifdef XVEC_LSU_MASK_EN
    assign start_mask = lane_mask_i;
`else
    assign start_mask = '1;
`endif

    assign misaligned = (base_addr_i[1:0] != 2'b00) || (stride_i[1:0] != 2'b00);

    // rem_q holds lanes still to issue; the lowest set bit is the lane in its address phase.
    always_comb begin
        cur_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (rem_q[i]) cur_lane = CNT_W'(i);
        end
    end

    always_comb begin
        wdata_lane = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (dp_lane_q == CNT_W'(i)) wdata_lane = sdata_q[i*XPR_LEN +: XPR_LEN];
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dp_valid_d = dp_valid_q;
        dp_lane_d  = dp_lane_q;
        is_store_d = is_store_q;
        err_d      = err_q;
        base_d     = base_q;
        stride_d   = stride_q;
        wa_d       = wa_q;
        sdata_d    = sdata_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    is_store_d = is_store_i;
                    base_d     = base_addr_i;
                    stride_d   = stride_i;
                    wa_d       = wa_i;
                    sdata_d    = store_data_i;
                    rem_d      = start_mask;
                    dp_valid_d = 1'b0;
                    err_d      = misaligned;
                    if (misaligned || (start_mask == '0)) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRun;
                    end
                    // Masked-off load lanes read back as zero.
                    if (!misaligned && !is_store_i) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (!start_mask[i]) wb_data_d[i*XPR_LEN +: XPR_LEN] = '0;
                        end
                    end
                end
            end
            StRun: begin
                if (!mem_wait_i) begin
                    if (dp_valid_q && !is_store_q) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (dp_lane_q == CNT_W'(i)) wb_data_d[i*XPR_LEN +: XPR_LEN] = mem_rdata_i;
                        end
                    end
                    dp_valid_d = 1'b1;
                    dp_lane_d  = cur_lane;
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (cur_lane == CNT_W'(i)) rem_d[i] = 1'b0;
                    end
                    if (rem_d == '0) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!mem_wait_i) begin
                    if (dp_valid_q && !is_store_q) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (dp_lane_q == CNT_W'(i)) wb_data_d[i*XPR_LEN +: XPR_LEN] = mem_rdata_i;
                        end
                    end
                    dp_valid_d = 1'b0;
                    state_d    = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_lane_q  <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            base_q     <= '0;
            stride_q   <= '0;
            wa_q       <= '0;
            sdata_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dp_valid_q <= dp_valid_d;
            dp_lane_q  <= dp_lane_d;
            is_store_q <= is_store_d;
            err_q      <= err_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            wa_q       <= wa_d;
            sdata_q    <= sdata_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StFin);
    assign err_o       = done_o && err_q;
    assign wb_en_o     = done_o && !is_store_q && !err_q;
    assign wb_addr_o   = wa_q;
    assign wb_data_o   = wb_data_q;
    assign mem_req_o   = (state_q == StRun);
    assign mem_wen_o   = mem_req_o && is_store_q;
    // Product wraps modulo 2^32, which also gives the right result for negative strides.
    assign mem_addr_o  = mem_req_o ? (base_q + 32'(cur_lane) * stride_q) : 32'd0;
    assign mem_wdata_o = (dp_valid_q && is_store_q) ? wdata_lane : '0;

endmodule

// File: doc/vscale_xvec_lsu.md
Name: vscale_xvec_lsu

Overview:
- Vector load/store sequencer for the xvec extension; sits between the DX/WB pipeline and the data-memory port.
- Loads: issues LANES strided word reads, assembles them into one LANES*XPR_LEN writeback word, and presents it on the vector register file's wide write port (lane i → element i of register wa).
- Stores: slices a wide source operand (rd2 of the vector register file) into LANES strided word writes.
- The pipeline stalls on busy.

Parameters:
- XPR_LEN, 32, lane width in bits (equals `XPR_LEN).
- LANES, 32, lanes per vector op (equals register-file lane count).
- CNT_W, 6, lane counter width (must hold LANES).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  op request; sampled only when busy=0.
- is_store  in  1  1=store, 0=load; sampled with start.
- base_addr  in  32  byte address of lane 0.
- stride  in  32  signed byte stride between lanes.
- wa  in  5  load destination register; captured at start.
- store_data  in  LANES*XPR_LEN  store source, lane i = [i*XPR_LEN +: XPR_LEN]; captured at start.
- busy  out  1  op in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misalignment abort.
- wb_en  out  1  one-cycle register-file write enable (loads only).
- wb_addr  out  5  destination register.
- wb_data  out  LANES*XPR_LEN  assembled load result.
- mem_req  out  1  address-phase valid.
- mem_wen  out  1  address-phase write flag.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  XPR_LEN  store data, driven in the data phase (one cycle after its address).
- mem_rdata  in  XPR_LEN  load data, valid in the data phase.
- mem_wait  in  1  memory stall; freezes the address and data phases.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; wb_data 0.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 captures all inputs and sets busy=1 on the next edge.
  - If base_addr[1:0]!=0 or stride[1:0]!=0, go to FIN with err=1; no mem_req is ever asserted.
  - Otherwise go to RUN.
- RUN:
  - mem_req=1, mem_addr = base + issue_idx*stride, modulo 2^32 (wrap, no fault).
  - Each cycle with mem_wait=0: the data phase of lane issue_idx-1 completes and issue_idx increments.
  - After lane LANES-1 issues, go to DRAIN.
- DRAIN: mem_req=0; wait for the last data phase to complete with mem_wait=0, then go to FIN.
- Data-phase handling: load data is captured into wb_data lane k when that lane's data phase completes. For stores, mem_wdata = captured lane k throughout its data phase.
- mem_wait=1:
  - Holds mem_req, mem_addr, mem_wdata and both counters.
  - Data is not captured during wait.
  - Holds in any state.
- FIN (exactly one cycle):
  - done=1; busy=0 on the following edge; return to IDLE.
  - For a load with err=0: wb_en=1 and wb_addr=wa in the same cycle.
  - Otherwise wb_en=0.
- Latency with no waits: start sampled at cycle 0; addresses in cycles 1..LANES; data phases in cycles 2..LANES+1; done at LANES+2 (34 for defaults).
- wb_addr=0: sequence runs normally; wb_en is still asserted. The register file suppresses the write.
- start while busy=1: ignored, no side effects.
- reset mid-operation: the next state is IDLE with all outputs 0. A pending data phase is abandoned, and no done/wb_en is produced.
- wb_data holds its last value until the next load's lanes overwrite it.

Optional Feature:
- Macro: XVEC_LSU_MASK_EN.
- Defined:
  - Adds input lane_mask[LANES-1:0], captured at start.
  - Lanes with mask=0 are skipped: no mem_req, and the counter advances in the same cycle.
  - Masked load lanes write 0 into wb_data.
  - All-zero mask goes IDLE→FIN directly (done at cycle 1).
  - Skipped lanes reduce latency by one cycle each.
- Undefined: no port; all lanes are active.

Test Plan:
- Load, base=0x100, stride=4, memory returns addr as data → wb_data lane i = 0x100+4i; done and wb_en at cycle 34; wb_addr=wa=5.
- Store, base=0x0000_0010, stride=-8 (0xFFFF_FFF8), lane i data = 0xA000+i → lane 3 written to 0xFFFF_FFF8 (wrap); 32 writes total; done at cycle 34; wb_en=0.
- Load with mem_wait=1 for 3 cycles while lane 5 is in its address phase → mem_addr held; lane 4 data captured only after wait drops; done at cycle 37; all lanes correct.
- base=0x102 → err=1 and done at cycle 1; mem_req never asserted; wb_en=0.
- Reset asserted at lane 10 of a load → next cycle busy=0, mem_req=0; no done; a new start then completes normally.
- start pulsed again while busy → ignored; exactly one done; with XVEC_LSU_MASK_EN, mask=0x0000_000F → 4 requests, lanes 4..31 = 0, done at cycle 6.
